// File: rtl/irq_frontend.sv
// Interrupt line conditioner: synchronise, detect, mask, latch and pace seven raw request lines.
// Latency: input rise to PENDING is SYNC_STAGES+1 edges, irqN pulses on the edge after that.
// Backpressure: none; a second request on a line while one is pending is flagged as OVERRUN.
module irq_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] line_in,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [6:0] cfg_wdata,
    output logic [6:0] cfg_rdata,
    output logic       irq1,
    output logic       irq2,
    output logic       irq3,
    output logic       irq4,
    output logic       irq5,
    output logic       irq6,
    output logic       irq7,
    output logic       irq_any
);

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_OVERRUN = 2'd3;
    localparam logic [7:0] HOLD_LOAD    = 8'(HOLDOFF);

    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [6:0]                  prev_q;
    logic [6:0]                  en_q, en_d;
    logic [6:0]                  mode_q, mode_d;
    logic [6:0]                  pend_q, pend_d;
    logic [6:0]                  ovr_q, ovr_d;
    logic [6:0][7:0]             hold_q, hold_d;
    logic [6:0]                  irq_q;
    logic                        any_q, any_d;

    logic [6:0] s_vec;
    logic [6:0] ev;
    logic [6:0] req;
    logic [6:0] fire;
    logic [6:0] hold_idle;
    logic [6:0] pend_clr;
    logic [6:0] ovr_clr;

    // Event detection, fire decision and next-state for all per-line state
    always_comb begin
        s_vec     = sync_q[SYNC_STAGES-1];
        // Edge lines need a fresh rise; level lines re-request every cycle they are high
        ev        = (mode_q & s_vec & ~prev_q) | (~mode_q & s_vec);
        req       = ev & en_q;
        hold_idle = '0;
        for (int n = 0; n < 7; n++) begin
            hold_idle[n] = (hold_q[n] == 8'd0);
        end
        fire      = pend_q & en_q & hold_idle;

        pend_clr  = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata : 7'd0;
        ovr_clr   = (cfg_we && cfg_addr == ADDR_OVERRUN) ? cfg_wdata : 7'd0;

        // A new request always wins over both the fire clear and a software clear
        pend_d    = req | (pend_q & ~fire & ~pend_clr);
        // Only edge lines can lose a request; level lines just stay pending
        ovr_d     = (req & pend_q & ~fire & mode_q) | (ovr_q & ~ovr_clr);

        en_d      = (cfg_we && cfg_addr == ADDR_ENABLE) ? cfg_wdata : en_q;
        mode_d    = (cfg_we && cfg_addr == ADDR_MODE)   ? cfg_wdata : mode_q;

        hold_d    = hold_q;
        for (int n = 0; n < 7; n++) begin
            if (fire[n]) begin
                hold_d[n] = HOLD_LOAD;
            end else if (!hold_idle[n]) begin
                hold_d[n] = hold_q[n] - 8'd1;
            end
        end

        any_d     = |(pend_q & en_q);
    end

    // Synchroniser chain and previous-sample register for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= line_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Config, pending/overrun, holdoff timers and registered pulse outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q   <= '0;
            mode_q <= 7'h7F;
            pend_q <= '0;
            ovr_q  <= '0;
            hold_q <= '0;
            irq_q  <= '0;
            any_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            hold_q <= hold_d;
            irq_q  <= fire;
            any_q  <= any_d;
        end
    end

    // Register read-back, selected combinationally by address
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE:  cfg_rdata = en_q;
            ADDR_MODE:    cfg_rdata = mode_q;
            ADDR_PENDING: cfg_rdata = pend_q;
            ADDR_OVERRUN: cfg_rdata = ovr_q;
            default:      cfg_rdata = '0;
        endcase
    end

    assign irq1    = irq_q[0];
    assign irq2    = irq_q[1];
    assign irq3    = irq_q[2];
    assign irq4    = irq_q[3];
    assign irq5    = irq_q[4];
    assign irq6    = irq_q[5];
    assign irq7    = irq_q[6];
    assign irq_any = any_q;

endmodule

// File: tb/tb_irq_frontend.sv
// Bench for irq_frontend: directed scenarios plus randomized traffic against a cycle model.
// Model keeps per-line sample history, integer holdoff counters and register images.
// Inputs change only on the falling edge; outputs compared after the falling edge.
module tb_irq_frontend;

    localparam int SS = 2;
    localparam int HO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] line_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [6:0] cfg_wdata;
    logic [6:0] cfg_rdata;
    logic       irq1, irq2, irq3, irq4, irq5, irq6, irq7, irq_any;

    always #5 clk = ~clk;

    irq_frontend #(.SYNC_STAGES(SS), .HOLDOFF(HO)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_in   (line_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq1      (irq1),
        .irq2      (irq2),
        .irq3      (irq3),
        .irq4      (irq4),
        .irq5      (irq5),
        .irq6      (irq6),
        .irq7      (irq7),
        .irq_any   (irq_any)
    );

    wire [6:0] irqv = {irq7, irq6, irq5, irq4, irq3, irq2, irq1};

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // m_hist[n][i] is line n as sampled i+1 edges ago; the synchronised view is
    // the sample SS edges old, the previous view the one SS+1 edges old.
    logic [6:0] m_en = '0, m_mode = 7'h7F, m_pend = '0, m_ovr = '0, m_irq = '0;
    logic       m_any = 1'b0;
    int         m_hold [7];
    logic [SS:0] m_hist [7];

    logic [6:0] nx_pend, nx_ovr, nx_irq;
    int         nx_hold [7];
    logic [SS:0] nx_hist [7];

    always_comb begin
        nx_pend = m_pend;
        nx_ovr  = m_ovr;
        nx_irq  = '0;
        nx_hold = m_hold;
        nx_hist = m_hist;
        for (int n = 0; n < 7; n++) begin
            logic now_hi, was_hi, event_n, request, fires, wipe_p, wipe_o;
            now_hi  = m_hist[n][SS-1];
            was_hi  = m_hist[n][SS];
            event_n = m_mode[n] ? (now_hi && !was_hi) : now_hi;
            request = event_n && m_en[n];
            fires   = m_pend[n] && m_en[n] && (m_hold[n] == 0);
            wipe_p  = cfg_we && (cfg_addr == 2'd2) && cfg_wdata[n];
            wipe_o  = cfg_we && (cfg_addr == 2'd3) && cfg_wdata[n];
            if (request)               nx_pend[n] = 1'b1;
            else if (fires || wipe_p)  nx_pend[n] = 1'b0;
            if (request && m_pend[n] && !fires && m_mode[n]) nx_ovr[n] = 1'b1;
            else if (wipe_o)                                  nx_ovr[n] = 1'b0;
            nx_irq[n]  = fires;
            nx_hold[n] = fires ? HO : ((m_hold[n] > 0) ? m_hold[n] - 1 : 0);
            nx_hist[n] = {m_hist[n][SS-1:0], line_in[n]};
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_en   <= '0;
            m_mode <= 7'h7F;
            m_pend <= '0;
            m_ovr  <= '0;
            m_irq  <= '0;
            m_any  <= 1'b0;
            for (int n = 0; n < 7; n++) begin
                m_hold[n] <= 0;
                m_hist[n] <= '0;
            end
        end else begin
            m_en   <= (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : m_en;
            m_mode <= (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : m_mode;
            m_pend <= nx_pend;
            m_ovr  <= nx_ovr;
            m_irq  <= nx_irq;
            m_any  <= |(m_pend & m_en);
            m_hold <= nx_hold;
            m_hist <= nx_hist;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    model_reg = m_en;
            2'd1:    model_reg = m_mode;
            2'd2:    model_reg = m_pend;
            default: model_reg = m_ovr;
        endcase
    endfunction

    // One clock, then compare every visible output against the model
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("irq_vec", 32'(irqv), 32'(m_irq));
        check("irq_any", 32'(irq_any), 32'(m_any));
        check("rdata", 32'(cfg_rdata), 32'(model_reg(cfg_addr)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [6:0] exp);
        cfg_addr = a;
        #1;
        check(tag, 32'(cfg_rdata), 32'(exp));
    endtask

    task automatic wr(input logic [1:0] a, input logic [6:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    // n_edges one-cycle-high pulses, two cycles apart, then watch for 14 cycles
    task automatic edge_train(input int ln, input int n_edges,
                              output int pulses, output int first_at, output int second_at);
        int idx;
        idx = 0; pulses = 0; first_at = -1; second_at = -1;
        for (int e = 0; e < 2 * n_edges + 14; e++) begin
            line_in[ln] = (e < 2 * n_edges) && (e % 2 == 0);
            step();
            if (irqv[ln]) begin
                pulses++;
                if (first_at < 0) first_at = idx;
                else if (second_at < 0) second_at = idx;
            end
            idx++;
        end
        line_in[ln] = 1'b0;
    endtask

    initial begin
        int hit_at, hits, last_at, p, f, s2;
        logic bad_gap;

        rst = 1'b0; line_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        idle(2);
        rst = 1'b1;
        check("rst_irq", 32'(irqv), 32'd0);
        rd_chk("rst_en", 2'd0, 7'h00);
        rd_chk("rst_mode", 2'd1, 7'h7F);
        rd_chk("rst_pend", 2'd2, 7'h00);
        rd_chk("rst_ovr", 2'd3, 7'h00);

        // single pulse on line 3: PENDING after third edge, irq3 on the fourth
        wr(2'd0, 7'h7F);
        idle(3);
        line_in = 7'h04;
        step();
        line_in = 7'h00;
        hits = 0; hit_at = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (irq3) begin hits++; hit_at = i; end
        end
        check("irq3_count", 32'(hits), 32'd1);
        check("irq3_latency", 32'(hit_at), 32'd3);
        rd_chk("irq3_pend_after", 2'd2, 7'h00);

        // level mode on line 1: pulses every HOLDOFF+1 cycles while high
        wr(2'd0, 7'h01);
        wr(2'd1, 7'h7E);
        idle(6);
        line_in[0] = 1'b1;
        hits = 0; last_at = -1; bad_gap = 1'b0;
        for (int i = 0; i < 26; i++) begin
            if (i == 20) line_in[0] = 1'b0;
            step();
            if (irq1) begin
                if (last_at >= 0 && (i - last_at) != HO + 1) bad_gap = 1'b1;
                last_at = i;
                hits++;
            end
        end
        check("level_gap_bad", 32'(bad_gap), 32'd0);
        check("level_pulses", 32'(hits >= 4), 32'd1);
        rd_chk("level_ovr", 2'd3, 7'h00);

        // two edges inside holdoff on line 5: two pulses five apart, no overrun
        wr(2'd1, 7'h7F);
        wr(2'd0, 7'h7F);
        idle(8);
        edge_train(4, 2, p, f, s2);
        check("l5_pulses", 32'(p), 32'd2);
        check("l5_spacing", 32'(s2 - f), 32'(HO + 1));
        rd_chk("l5_ovr_none", 2'd3, 7'h00);
        // third edge lands while the second is still pending
        edge_train(4, 3, p, f, s2);
        rd_chk("l5_ovr_set", 2'd3, 7'h10);

        // disabled line 7: event dropped, enabling later does not replay it
        wr(2'd0, 7'h00);
        idle(4);
        line_in[6] = 1'b1; step(); line_in[6] = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin step(); if (irq7) hits++; end
        check("l7_disabled", 32'(hits), 32'd0);
        wr(2'd0, 7'h40);
        for (int i = 0; i < 8; i++) begin step(); if (irq7) hits++; end
        check("l7_no_replay", 32'(hits), 32'd0);
        line_in[6] = 1'b1; step(); line_in[6] = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); if (irq7) hits++; end
        check("l7_new_edge", 32'(hits), 32'd1);
        wr(2'd3, 7'h7F);
        rd_chk("ovr_w1c", 2'd3, 7'h00);

        // simultaneous edges on lines 1, 4, 6
        wr(2'd0, 7'h7F);
        idle(10);
        line_in = 7'b0101001; step(); line_in = 7'h00;
        hit_at = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (irqv != 7'h00 && hit_at < 0) begin
                hit_at = i;
                check("multi_vec", 32'(irqv), 32'h29);
                check("multi_any_hi", 32'(irq_any), 32'd1);
                step();
                check("multi_vec_off", 32'(irqv), 32'd0);
                check("multi_any_lo", 32'(irq_any), 32'd0);
            end
        end
        check("multi_seen", 32'(hit_at >= 0), 32'd1);

        // retained PENDING[1] with ENABLE = 0, then reset wipes it
        wr(2'd0, 7'h02);
        idle(8);
        for (int e = 0; e < 5; e++) begin
            line_in[1] = (e == 0 || e == 2);
            step();
        end
        line_in[1] = 1'b0;
        wr(2'd0, 7'h00);
        rd_chk("pend_retained", 2'd2, 7'h02);
        rst = 1'b0; step(); rst = 1'b1;
        rd_chk("rst2_pend", 2'd2, 7'h00);
        rd_chk("rst2_ovr", 2'd3, 7'h00);
        rd_chk("rst2_en", 2'd0, 7'h00);
        rd_chk("rst2_mode", 2'd1, 7'h7F);
        check("rst2_irq", 32'(irqv), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 7; n++) begin
                if ($urandom_range(0, 3) == 0) line_in[n] = ~line_in[n];
            end
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = 7'($urandom);
            rst       = ($urandom_range(0, 199) != 0);
            step();
        end
        cfg_we = 1'b0;
        rst    = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
